// File: rtl/matrix_mult_pkg.sv
// Shared types for the matrix-multiply array edge blocks.
// Drain FSM states, result-vector layout and window helper.
package matrix_mult_pkg;

  localparam int P_WIDTH = 8;
  localparam int P_ROW   = 4;
  localparam int P_COL   = 4;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_CAPTURE
  } drain_state_e;

  typedef struct packed {
    logic                           last;
    logic [P_COL-1:0][P_WIDTH-1:0] data;
  } res_vec_t;

  function automatic int win_len(int row, int col);
    return row + col - 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and zeroed output when empty.
// Push and pop may coincide at any occupancy, including full.
module sync_fifo #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          din_i,
  output logic [DATA_W-1:0]          dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/systolic_drain.sv
// De-skews diagonal south outputs of the systolic array into
// row-aligned result vectors and streams them out of a FIFO.
module systolic_drain
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [COL-1:0][WIDTH-1:0]  south_i,
  output logic                       start_ready_o,
  output logic                       busy_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [COL-1:0][WIDTH-1:0]  m_data_o,
  output logic                       m_last_o,
  output logic                       err_o
);

  localparam int WIN  = win_len(ROW, COL);
  localparam int CNTW = $clog2(WIN) + 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int DW   = COL * WIDTH + 1;

  drain_state_e    state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [COL-1:0][WIDTH-1:0] aligned;
  logic [DW-1:0]             din, dout;
  logic [CW-1:0]             count, free;
  logic                      push, pop, full, empty, last;

  // Column c needs COL-1-c stages so every column lines up with the last.
  for (genvar c = 0; c < COL; c++) begin : g_col
    localparam int L = COL - 1 - c;
    if (L == 0) begin : g_direct
      assign aligned[c] = south_i[c];
    end else begin : g_dly
      logic [L-1:0][WIDTH-1:0] dl_q;
      always_ff @(posedge clk_i) begin
        dl_q[0] <= south_i[c];
        for (int j = 1; j < L; j++) dl_q[j] <= dl_q[j-1];
      end
      assign aligned[c] = dl_q[L-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DRAIN_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (start_i & ~start_ready_o);
    unique case (state_q)
      DRAIN_IDLE: begin
        if (start_i && start_ready_o) begin
          state_d = DRAIN_CAPTURE;
          cnt_d   = CNTW'(1);
        end
      end
      DRAIN_CAPTURE: begin
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIN - 1)) begin
          state_d = DRAIN_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  assign free = CW'(DEPTH) - count;

  always_comb begin
    start_ready_o = 1'b0;
    busy_o        = 1'b0;
    push          = 1'b0;
    last          = 1'b0;
    unique case (state_q)
      DRAIN_IDLE: start_ready_o = (free >= CW'(ROW));
      DRAIN_CAPTURE: begin
        busy_o = 1'b1;
        push   = (cnt_q >= CNTW'(COL - 1)) && !full;
        last   = (cnt_q == CNTW'(WIN - 1));
      end
      default: ;
    endcase
  end

  assign din       = {last, aligned};
  assign m_valid_o = !empty;
  assign pop       = m_valid_o && m_ready_i;
  assign m_data_o  = dout[DW-2:0];
  assign m_last_o  = dout[DW-1];
  assign err_o     = err_q;

  sync_fifo #(
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (din),
    .dout_o (dout),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain with a row scoreboard and
// hold-stability checking folded into the clock step task.
module tb_systolic_drain;

  logic             clk = 1'b0;
  logic             rst_i, start_i, m_ready_i;
  logic [3:0][7:0]  south_i;
  logic             start_ready_o, busy_o, m_valid_o, m_last_o, err_o;
  logic [3:0][7:0]  m_data_o;

  int               errs = 0;
  int               checks = 0;
  int               ph = 100;
  logic [7:0]       mat [4][4];
  logic [32:0]      expq [$];
  logic             hold_q = 1'b0;
  logic [32:0]      hold_v = '0;

  always #5 clk = ~clk;

  systolic_drain #(
    .WIDTH(8), .ROW(4), .COL(4), .DEPTH(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .south_i      (south_i),
    .start_ready_o(start_ready_o),
    .busy_o       (busy_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .err_o        (err_o)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(logic [7:0] base);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        mat[k][c] = base + 8'(16 * k + c);
  endtask

  task automatic expect_tile();
    for (int k = 0; k < 4; k++)
      expq.push_back({k == 3, mat[k][3], mat[k][2], mat[k][1], mat[k][0]});
  endtask

  task automatic tick();
    logic [32:0] e;
    for (int c = 0; c < 4; c++) begin
      int k;
      k = ph - c;
      south_i[c] = (k >= 0 && k < 4) ? mat[k][c] : 8'h5A;
    end
    if (hold_q) chk("hold", {m_last_o, m_data_o}, hold_v);
    if (m_valid_o && m_ready_i) begin
      if (expq.size() == 0) chk("spurious_pop", m_valid_o, 0);
      else begin
        e = expq.pop_front();
        chk("pop_row", {m_last_o, m_data_o}, e);
      end
    end
    hold_q = m_valid_o && !m_ready_i;
    hold_v = {m_last_o, m_data_o};
    @(posedge clk);
    #1;
    ph++;
  endtask

  task automatic go();
    start_i = 1'b1;
    ph = 0;
    tick();
    start_i = 1'b0;
  endtask

  task automatic bad_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    m_ready_i = 1'b1;
    south_i = '0;
    fill(8'h00);
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_ready", start_ready_o, 1);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", {m_last_o, m_data_o}, 0);

    // single tile, always ready
    expect_tile();
    go();
    for (int cy = 1; cy <= 8; cy++) begin
      chk("t1_busy", busy_o, cy <= 6);
      chk("t1_valid", m_valid_o, cy >= 4 && cy <= 7);
      chk("t1_last", m_last_o, cy == 7);
      if (cy == 4) chk("t1_row0", m_data_o, 32'h03020100);
      if (cy == 7) chk("t1_row3", m_data_o, 32'h33323130);
      if (cy == 8) chk("t1_empty", m_data_o, 0);
      tick();
    end

    // backpressure: two tiles fill the FIFO
    m_ready_i = 1'b0;
    fill(8'h08);
    expect_tile();
    go();
    repeat (6) tick();
    chk("t2_ready_a", start_ready_o, 1);
    fill(8'h80);
    expect_tile();
    go();
    repeat (6) tick();
    chk("t2_count", dut.u_fifo.count_o, 8);
    chk("t2_ready_b", start_ready_o, 0);
    chk("t2_err_pre", err_o, 0);
    bad_start();
    chk("t2_err", err_o, 1);
    chk("t2_count2", dut.u_fifo.count_o, 8);
    chk("t2_busy", busy_o, 0);
    tick();
    m_ready_i = 1'b1;
    repeat (8) tick();
    chk("t2_drained", expq.size(), 0);
    chk("t2_valid", m_valid_o, 0);

    // random backpressure during a drain
    fill(8'h40);
    expect_tile();
    go();
    repeat (29) begin
      m_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready_i = 1'b1;
    repeat (5) tick();
    chk("t3_drained", expq.size(), 0);

    // back-to-back tiles
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t4_err0", err_o, 0);
    fill(8'h20);
    expect_tile();
    go();
    repeat (6) tick();
    chk("t4_ready7", start_ready_o, 1);
    fill(8'hA0);
    expect_tile();
    go();
    chk("t4_err_ok", err_o, 0);
    chk("t4_busy", busy_o, 1);
    repeat (5) tick();
    chk("t4_ready6", start_ready_o, 0);
    bad_start();
    chk("t4_err_early", err_o, 1);

    // reset in cycle 4 of a tile
    fill(8'h60);
    expect_tile();
    go();
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    expq.delete();
    chk("t5_valid", m_valid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_err", err_o, 0);
    chk("t5_data", {m_last_o, m_data_o}, 0);
    chk("t5_ready", start_ready_o, 1);
    fill(8'h11);
    expect_tile();
    go();
    repeat (10) tick();
    chk("t5_drained", expq.size(), 0);

    // signed extremes
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        mat[k][c] = (k % 2 == 0) ? 8'h80 : 8'h7F;
    expect_tile();
    go();
    repeat (3) tick();
    chk("t6_row0", m_data_o, 32'h80808080);
    tick();
    chk("t6_row1", m_data_o, 32'h7F7F7F7F);
    repeat (6) tick();
    chk("t6_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
